// File: rtl/result_wb_ctrl.sv
// Write-back controller: buffers 64-bit result rows and writes them in order to the dp result BRAM.
// Define WB_ACCUM_EN to read-modify-write each word (lane-wise 16-bit add onto the stored partial).
module result_wb_ctrl #(
  parameter logic [31:0] RES_BASE   = 32'd0,
  parameter logic [31:0] ADDR_STEP  = 32'd8,
  parameter int          NUM_BLOCKS = 336,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calc_init,
  input  logic [2:0]  mem_mode,
  input  logic        res_valid,
  input  logic [63:0] res_data,
  output logic        res_ready,
  output logic        dp_we,
  output logic        dp_re,
  output logic [31:0] addr_dp,
  output logic [63:0] wdata_dp,
  input  logic [63:0] rdata_dp,
  output logic        wb_busy,
  output logic        wb_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BLK_W = $clog2(NUM_BLOCKS + 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_ACC_RD = 3'd2,
    S_ACC_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [63:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [1:0]       r_row;
  logic [BLK_W-1:0] r_blk;
  logic             r_dp_we, r_wb_busy, r_wb_done;
  logic [31:0]      r_addr;

  logic        w_full, w_empty, w_push, w_pop, w_adv, w_last, w_run;
  logic        w_we_nxt, w_done_nxt, w_busy_nxt;
  logic [31:0] w_word, w_addr, w_addr_nxt;
  logic [63:0] w_head;

`ifdef WB_ACCUM_EN
  logic        r_dp_re, w_re_nxt;
  logic [63:0] r_acc_row;

  function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < 4; i++) s[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
    return s;
  endfunction
`else
  logic [63:0] r_wdata, w_wdata_nxt;
  logic        w_unused_rdata;
`endif

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_run   = (r_state == S_RUN) || (r_state == S_ACC_RD) || (r_state == S_ACC_WR);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign res_ready = w_run && (!w_full || w_pop) && !calc_init;
  assign w_push    = res_valid && res_ready;
  assign w_word    = 32'({r_blk, r_row});
  assign w_addr    = RES_BASE + w_word * ADDR_STEP;
  assign w_last    = (r_blk == LAST_BLK) && (r_row == 2'd3);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = 32'd0;
`ifdef WB_ACCUM_EN
    w_re_nxt    = 1'b0;
`else
    w_wdata_nxt = 64'd0;
`endif
    if (calc_init) begin
      w_state_nxt = (mem_mode != 3'd0) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_RUN: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_addr_nxt = w_addr;
`ifdef WB_ACCUM_EN
            w_re_nxt    = 1'b1;
            w_state_nxt = S_ACC_RD;
`else
            w_we_nxt    = 1'b1;
            w_wdata_nxt = w_head;
            w_adv       = 1'b1;
            w_done_nxt  = w_last;
            w_state_nxt = w_last ? S_DONE : S_RUN;
`endif
          end else begin
            w_state_nxt = S_RUN;
          end
        end
`ifdef WB_ACCUM_EN
        S_ACC_RD: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_addr;
          w_adv       = 1'b1;
          w_done_nxt  = w_last;
          w_state_nxt = S_ACC_WR;
        end
        S_ACC_WR: begin
          if (r_wb_done) begin
            w_state_nxt = S_DONE;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_addr_nxt  = w_addr;
            w_re_nxt    = 1'b1;
            w_state_nxt = S_ACC_RD;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
`endif
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_ACC_RD) ||
                 (w_state_nxt == S_ACC_WR) || w_we_nxt;
  end

  // State, registered BRAM strobes and word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dp_we   <= 1'b0;
      r_wb_busy <= 1'b0;
      r_wb_done <= 1'b0;
      r_addr    <= 32'd0;
      r_row     <= 2'd0;
      r_blk     <= '0;
`ifdef WB_ACCUM_EN
      r_dp_re   <= 1'b0;
      r_acc_row <= 64'd0;
`else
      r_wdata   <= 64'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_dp_we   <= w_we_nxt;
      r_wb_busy <= w_busy_nxt;
      r_wb_done <= w_done_nxt;
      r_addr    <= w_addr_nxt;
`ifdef WB_ACCUM_EN
      r_dp_re   <= w_re_nxt;
      r_acc_row <= w_pop ? w_head : r_acc_row;
`else
      r_wdata   <= w_wdata_nxt;
`endif
      if (calc_init) begin
        r_row <= 2'd0;
        r_blk <= '0;
      end else if (w_adv) begin
        r_row <= r_row + 2'd1;
        r_blk <= (r_row == 2'd3) ? r_blk + BLK_W'(1) : r_blk;
      end else begin
        r_row <= r_row;
        r_blk <= r_blk;
      end
    end
  end

  // Row FIFO; calc_init discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 64'd0;
    end else if (calc_init) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= res_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dp_we   = r_dp_we;
  assign addr_dp = r_addr;
  assign wb_busy = r_wb_busy;
  assign wb_done = r_wb_done;
`ifdef WB_ACCUM_EN
  assign dp_re    = r_dp_re;
  // Read data lands in the write cycle, so the sum is formed combinationally there.
  assign wdata_dp = r_dp_we ? lane_add(rdata_dp, r_acc_row) : 64'd0;
`else
  assign dp_re          = 1'b0;
  assign wdata_dp       = r_wdata;
  assign w_unused_rdata = ^rdata_dp;
`endif

endmodule

// File: tb/tb_result_wb_ctrl.sv
// Directed scoreboard bench for result_wb_ctrl (NUM_BLOCKS=2, FIFO_DEPTH=4); works with or without WB_ACCUM_EN.
module tb_result_wb_ctrl;
  localparam int          NB       = 2;
  localparam logic [63:0] RD_CONST = 64'hFFFF_0001_8000_0000;
  localparam logic [63:0] T6_ROW   = 64'h0001_FFFF_8000_0005;
`ifdef WB_ACCUM_EN
  localparam bit          ACC        = 1'b1;
  localparam logic [63:0] T6_EXP     = 64'h0000_0000_0000_0005;
  localparam logic        PROBE_RDY  = 1'b0;
`else
  localparam bit          ACC        = 1'b0;
  localparam logic [63:0] T6_EXP     = T6_ROW;
  localparam logic        PROBE_RDY  = 1'b1;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, calc_init = 1'b0;
  logic [2:0]  mem_mode = 3'd0;
  logic        res_valid = 1'b0;
  logic [63:0] res_data = 64'd0, rdata_dp = 64'd0;
  logic        res_ready, dp_we, dp_re, wb_busy, wb_done;
  logic [31:0] addr_dp;
  logic [63:0] wdata_dp;

  int checks = 0, failures = 0;
  int exp_w = 0, rd_idx = 0;
  logic [31:0] exp_a[$];
  logic [63:0] exp_d[$];

  logic [31:0] obs_addr [128];
  logic [63:0] obs_data [128];
  int          obs_cnt = 0, done_cnt = 0, re_cnt = 0;
  logic [31:0] done_addr = 32'd0;
`ifdef WB_ACCUM_EN
  int          seq_err = 0;
  logic        prev_re = 1'b0;
  logic [31:0] prev_addr = 32'd0;
`endif

  result_wb_ctrl #(.RES_BASE(32'd0), .ADDR_STEP(32'd8), .NUM_BLOCKS(NB), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .calc_init(calc_init), .mem_mode(mem_mode),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .dp_we(dp_we), .dp_re(dp_re), .addr_dp(addr_dp), .wdata_dp(wdata_dp),
    .rdata_dp(rdata_dp), .wb_busy(wb_busy), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  // BRAM read port: address-dependent data one cycle after dp_re, garbage otherwise.
  always @(posedge clk) rdata_dp <= dp_re ? (RD_CONST ^ {32'd0, addr_dp}) : 64'hBADB_ADBA_DBAD_BAD0;

  // Output monitor.
  always @(negedge clk) begin
    if (dp_we) begin
      if (obs_cnt < 128) begin
        obs_addr[obs_cnt] <= addr_dp;
        obs_data[obs_cnt] <= wdata_dp;
      end
      obs_cnt <= obs_cnt + 1;
`ifdef WB_ACCUM_EN
      if (!(prev_re && (prev_addr == addr_dp))) seq_err <= seq_err + 1;
`endif
    end
    if (dp_re) re_cnt <= re_cnt + 1;
    if (wb_done) begin
      done_cnt  <= done_cnt + 1;
      done_addr <= addr_dp;
    end
`ifdef WB_ACCUM_EN
    prev_re   <= dp_re;
    prev_addr <= addr_dp;
`endif
  end

  function automatic logic [63:0] model_wdata(input logic [31:0] a, input logic [63:0] row);
    logic [63:0] rd, s;
    rd = RD_CONST ^ {32'd0, a};
    for (int i = 0; i < 4; i++) s[16*i +: 16] = rd[16*i +: 16] + row[16*i +: 16];
    return ACC ? s : row;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [2:0] mode);
    calc_init = 1'b1;
    mem_mode  = mode;
    sync();
    calc_init = 1'b0;
    exp_w     = 0;
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic send(input logic [63:0] d);
    bit got;
    logic [31:0] a;
    got = 1'b0;
    res_valid = 1'b1;
    res_data  = d;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (res_ready) begin
        a = 32'(exp_w) * 32'd8;
        exp_a.push_back(a);
        exp_d.push_back(model_wdata(a, d));
        exp_w++;
        got = 1'b1;
        sync();
      end
    end
    res_valid = 1'b0;
    chk("send_accepted", {63'd0, got}, 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && (obs_cnt - rd_idx) < exp_a.size(); c++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 64'(obs_cnt - rd_idx), 64'(exp_a.size()));
    while (exp_a.size() > 0 && rd_idx < obs_cnt) begin
      chk({tag, "_addr"}, {32'd0, obs_addr[rd_idx]}, {32'd0, exp_a.pop_front()});
      chk({tag, "_data"}, obs_data[rd_idx], exp_d.pop_front());
      rd_idx++;
    end
    exp_a.delete();
    exp_d.delete();
    rd_idx = obs_cnt;
    sync();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_res_ready"}, {63'd0, res_ready}, 64'd0);
    chk({tag, "_dp_we"},     {63'd0, dp_we},     64'd0);
    chk({tag, "_dp_re"},     {63'd0, dp_re},     64'd0);
    chk({tag, "_wb_busy"},   {63'd0, wb_busy},   64'd0);
    chk({tag, "_wb_done"},   {63'd0, wb_done},   64'd0);
    chk({tag, "_addr_dp"},   {32'd0, addr_dp},   64'd0);
    chk({tag, "_wdata_dp"},  wdata_dp,           64'd0);
  endtask

  initial begin
    int cnt, j0, d0, n;
    logic probe;

    // Reset values
    repeat (2) sync();
    check_quiet("reset");
    rst_n = 1'b1;
    sync();

    // T5: mem_mode 0 keeps the block idle even with rows offered
    start_job(3'd0);
    cnt = 0;
    n = obs_cnt;
    res_valid = 1'b1;
    res_data  = 64'h1111_2222_3333_4444;
    repeat (20) begin
      @(negedge clk);
      if (res_ready) cnt++;
    end
    res_valid = 1'b0;
    chk("t5_ready_cycles", 64'(cnt), 64'd0);
    chk("t5_writes", 64'(obs_cnt - n), 64'd0);
    chk("t5_busy", {63'd0, wb_busy}, 64'd0);
    sync();

    // T2: AS job, 8 back-to-back rows, addresses 0..56, one done pulse on the last
    start_job(3'd1);
    chk("t2_busy", {63'd0, wb_busy}, 64'd1);
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) send(64'h0001_0002_0003_0004 + 64'(k));
    drain("t2", 60);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t2_done_addr", {32'd0, done_addr}, 64'd56);
    cnt = 0;
    res_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (res_ready) cnt++;
    end
    res_valid = 1'b0;
    chk("t2_done_ready", 64'(cnt), 64'd0);
    chk("t2_done_busy", {63'd0, wb_busy}, 64'd0);
    sync();

    // T3/T6: SA job, lane-wrap row first, then a ninth row probes FIFO space
    start_job(3'd2);
    j0 = rd_idx;
    send(T6_ROW);
    for (int k = 1; k < 8; k++) send({$urandom, $urandom});
    res_valid = 1'b1;
    res_data  = 64'hDEAD_0000_0000_0009;
    @(negedge clk);
    probe = res_ready;
    sync();
    res_valid = 1'b0;
    chk("t3_ninth_row_ready", {63'd0, probe}, {63'd0, PROBE_RDY});
    drain("t3", 80);
    chk("t6_first_wdata", obs_data[j0], T6_EXP);
`ifdef WB_ACCUM_EN
    chk("t6_re_before_we", 64'(seq_err), 64'd0);
    chk("t6_re_count", 64'(re_cnt), 64'(obs_cnt));
`else
    chk("t6_no_dp_re", 64'(re_cnt), 64'd0);
`endif

    // T4: calc_init mid-job drops buffered rows and restarts addressing
    start_job(3'd3);
    for (int k = 0; k < 5; k++) send(64'hA5A5_0000_0000_0000 + 64'(k));
    calc_init = 1'b1;
    mem_mode  = 3'd4;
    sync();
    calc_init = 1'b0;
    repeat (3) @(negedge clk);
    n = obs_cnt - rd_idx;
    chk("t4_rows_dropped", 64'(n < 5), 64'd1);
    while (n > 0) begin
      chk("t4_pre_addr", {32'd0, obs_addr[rd_idx]}, {32'd0, exp_a.pop_front()});
      chk("t4_pre_data", obs_data[rd_idx], exp_d.pop_front());
      rd_idx++;
      n--;
    end
    exp_a.delete();
    exp_d.delete();
    exp_w = 0;
    repeat (10) @(negedge clk);
    chk("t4_no_stale_writes", 64'(obs_cnt - rd_idx), 64'd0);
    sync();
    send(64'h0102_0304_0506_0708);
    send(64'h1112_1314_1516_1718);
    drain("t4_restart", 40);

    // T1: asynchronous reset after five writes
    start_job(3'd1);
    for (int k = 0; k < 5; k++) send(64'h5555_0000_0000_0010 + 64'(k));
    drain("t1", 40);
    rst_n = 1'b0;
    #1;
    check_quiet("t1_async");
    sync();
    check_quiet("t1_edge");
    rst_n = 1'b1;
    sync();
    start_job(3'd1);
    n = obs_cnt;
    repeat (10) @(negedge clk);
    chk("t1_fifo_empty", 64'(obs_cnt - n), 64'd0);
    chk("t1_busy_after", {63'd0, wb_busy}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
